fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction word used for bubbles (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port PCWrite  input  1  from hazard unit; 0 holds the PC.
REQ-006 SHALL have port IFIDWrite  input  1  from hazard unit; 0 holds the IF/ID register.
REQ-007 SHALL have port Flush  input  1  redirect request; the IF/ID entry becomes a bubble and fetch moves to Jump_Target.
REQ-008 SHALL have port Jump_Target  input  32  redirect address, sampled only when Flush=1.
REQ-009 SHALL have port imem_rdata  input  32  instruction word for imem_addr.
REQ-010 SHALL have port imem_valid  input  1  imem_rdata is valid this cycle (same-cycle response allowed).
REQ-011 SHALL have port imem_addr  output  32  fetch address, equal to the PC register.
REQ-012 SHALL have port IFID_PC / IFID_Instr / IFID_Valid  output  32/32/1  IF/ID pipeline register contents.
REQ-013 SHALL have port perf_stall_cnt / perf_flush_cnt  output  32/32  performance counters (FETCH_PERF_EN only).

Function
REQ-014 SHALL implement states FETCH and DISCARD; imem_addr SHALL stay stable on every cycle imem_valid=0 (no address change while a fetch is outstanding).
REQ-015 FETCH, imem_valid=1, Flush=1: PC<=Jump_Target, IF/ID<=bubble, regardless of PCWrite/IFIDWrite (Flush has priority).
REQ-016 FETCH, imem_valid=1, Flush=0: if PCWrite, PC<=PC+4 (mod 2^32, wraps 0xFFFF_FFFC->0); if IFIDWrite, IF/ID<={PC, imem_rdata, 1}; else hold.
REQ-017 FETCH, imem_valid=0, Flush=0: PC held; IF/ID<=bubble if IFIDWrite=1, else held.
REQ-018 FETCH, imem_valid=0, Flush=1: PC held, pending_target<=Jump_Target, IF/ID<=bubble, next state DISCARD.
REQ-019 DISCARD: IF/ID written with bubble when IFIDWrite=1 or Flush=1; Flush=1 overwrites pending_target (latest wins).
REQ-020 DISCARD, imem_valid=1: returned word dropped, PC<=pending_target (or Jump_Target if Flush=1 same cycle), next state FETCH.
REQ-021 Bubble SHALL be IFID_PC=0, IFID_Instr=NOP_INSTR, IFID_Valid=0.
REQ-022 Latency: instruction returned at PC in cycle N SHALL appear on IFID_* in cycle N+1.
REQ-023 Jump_Target low bits SHALL be used unmodified (no alignment masking).

Reset
REQ-024 On rst=1 at a clock edge: PC<=RESET_PC, state<=FETCH, IF/ID<=bubble, pending_target<=0, counters<=0; overrides all other inputs.
REQ-025 Reset asserted during DISCARD SHALL abandon the pending redirect; the first fetch after reset is RESET_PC.

Configuration
REQ-026 Macro FETCH_PERF_EN defined: perf_stall_cnt SHALL increment each cycle PCWrite=0 or imem_valid=0 (outside reset); perf_flush_cnt SHALL increment each cycle Flush=1; both saturate at 32'hFFFF_FFFF.
REQ-027 Macro FETCH_PERF_EN undefined: perf_* ports SHALL be absent and no counter logic present; all other behaviour identical.

Verification
REQ-028 Reset, imem_valid=1 constant, PCWrite=IFIDWrite=1 -> imem_addr 0,4,8; IFID_PC lags one cycle, IFID_Valid=1 from second cycle.
REQ-029 PC=0x10, PCWrite=IFIDWrite=0 for 2 cycles -> imem_addr stays 0x10, IFID_* held unchanged, perf_stall_cnt +2.
REQ-030 PC=0x20, Flush=1, Jump_Target=0x100, imem_valid=1 -> next cycle imem_addr=0x100, IFID_Valid=0, IFID_Instr=0x0000_0013.
REQ-031 PC=0x40, imem_valid=0, Flush=1 target 0x200, imem_valid=0 two more cycles then 1 -> imem_addr 0x40 throughout, word dropped, then imem_addr=0x200.
REQ-032 In DISCARD, second Flush target 0x300 before imem_valid -> PC becomes 0x300, not first target.
REQ-033 PC=0xFFFF_FFFC, normal advance -> imem_addr=0x0000_0000; rst=1 mid-DISCARD -> imem_addr=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage. It holds the PC and the IF/ID pipeline register and
//   handles hazard-unit stalls and redirects (Flush). A redirect that arrives
//   while an instruction-memory read is still outstanding parks its target in
//   pending_target and enters DISCARD. The late word is then dropped, so the
//   fetch address never changes while a read is in flight.
//
//   Optional feature: define FETCH_PERF_EN to add saturating stall and flush
//   performance counters (ports perf_stall_cnt / perf_flush_cnt).
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        Flush,
    input  logic [31:0] Jump_Target,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] imem_addr,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_Instr,
    output logic        IFID_Valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        load_bubble;
    logic        load_fetched;

    // Next-state logic: redirect handling, stall/hold, and IF/ID update.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = pending_q;
        load_bubble  = 1'b0;
        load_fetched = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (imem_valid) begin
                    if (Flush) begin
                        // A redirect outranks both hazard-unit hold requests.
                        pc_d        = Jump_Target;
                        load_bubble = 1'b1;
                    end else begin
                        if (PCWrite)   pc_d         = pc_q + 32'd4;
                        if (IFIDWrite) load_fetched = 1'b1;
                    end
                end else if (Flush) begin
                    // The read is still in flight, so keep the address and remember the target.
                    pending_d   = Jump_Target;
                    load_bubble = 1'b1;
                    state_d     = DISCARD;
                end else begin
                    load_bubble = IFIDWrite;
                end
            end
            DISCARD: begin
                load_bubble = IFIDWrite | Flush;
                if (Flush) pending_d = Jump_Target;
                if (imem_valid) begin
                    // Drop the stale word and move on to the most recent target.
                    pc_d    = Flush ? Jump_Target : pending_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (load_bubble) begin
            ifid_pc_d    = 32'h0000_0000;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (load_fetched) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
        end
    end

    // State registers with synchronous reset. Reset overrides all other inputs.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so that every flop samples pre-edge values.
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pending_q    <= 32'h0000_0000;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_addr  = pc_q;
    assign IFID_PC    = ifid_pc_q;
    assign IFID_Instr = ifid_instr_q;
    assign IFID_Valid = ifid_valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters for stall cycles (hold or memory wait) and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'h0000_0000;
            flush_cnt_q <= 32'h0000_0000;
        end else begin
            if ((!PCWrite || !imem_valid) && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (Flush && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. The reference model tracks the PC, an
//   "a redirect is waiting for the in-flight read" flag with its target, and
//   the IF/ID contents. The model is updated from the rules once per clock.
//   Perf counters are checked when FETCH_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, IFIDWrite, Flush, imem_valid;
    logic [31:0] Jump_Target, imem_rdata;
    logic [31:0] imem_addr, IFID_PC, IFID_Instr;
    logic        IFID_Valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_pc, m_target, m_ifid_pc, m_ifid_instr;
    logic        m_waiting, m_ifid_valid;
    logic [31:0] m_stall, m_flush;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .IFIDWrite   (IFIDWrite),
        .Flush       (Flush),
        .Jump_Target (Jump_Target),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .imem_addr   (imem_addr),
        .IFID_PC     (IFID_PC),
        .IFID_Instr  (IFID_Instr),
        .IFID_Valid  (IFID_Valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic bubble_model();
        m_ifid_pc    = 32'h0;
        m_ifid_instr = NOP;
        m_ifid_valid = 1'b0;
    endtask

    // Apply the rules for one rising edge, using the inputs currently driven.
    task automatic model_step();
        if (rst) begin
            m_pc = RESET_PC; m_target = 32'h0; m_waiting = 1'b0;
            m_stall = 32'h0; m_flush = 32'h0;
            bubble_model();
        end else begin
            if ((!PCWrite || !imem_valid) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (Flush && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
            if (m_waiting) begin
                if (Flush) m_target = Jump_Target;
                if (Flush || IFIDWrite) bubble_model();
                if (imem_valid) begin
                    m_pc = m_target;
                    m_waiting = 1'b0;
                end
            end else if (imem_valid && Flush) begin
                m_pc = Jump_Target;
                bubble_model();
            end else if (imem_valid) begin
                if (IFIDWrite) begin
                    m_ifid_pc = m_pc; m_ifid_instr = imem_rdata; m_ifid_valid = 1'b1;
                end
                if (PCWrite) m_pc = m_pc + 32'd4;
            end else if (Flush) begin
                m_target = Jump_Target;
                m_waiting = 1'b1;
                bubble_model();
            end else if (IFIDWrite) begin
                bubble_model();
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model at the
    // rising edge, and return 1 time unit later so outputs can be sampled.
    task automatic drive(input logic r, input logic pcw, input logic ifw,
                         input logic fl, input logic [31:0] jt, input logic v);
        @(negedge clk);
        rst = r; PCWrite = pcw; IFIDWrite = ifw; Flush = fl;
        Jump_Target = jt; imem_valid = v; imem_rdata = $urandom;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic go_to(input logic [31:0] addr);
        drive(1'b0, 1'b1, 1'b1, 1'b1, addr, 1'b1);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 1'b0);
        checks++;
        if (imem_addr !== RESET_PC) begin
            errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC);
        end
        checks++;
        if ({IFID_PC, IFID_Instr, IFID_Valid} !== {32'h0, NOP, 1'b0}) begin
            errors++; $display("FAIL reset_ifid: got %h/%h/%b expected 0/%h/0", IFID_PC, IFID_Instr, IFID_Valid, NOP);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if ({perf_stall_cnt, perf_flush_cnt} !== 64'h0) begin
            errors++; $display("FAIL reset_perf: got %h/%h expected 0/0", perf_stall_cnt, perf_flush_cnt);
        end
`endif
    endtask

    task automatic test_sequential();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_addr !== 32'(4 * i)) begin
                errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr, 32'(4 * i));
            end
            checks++;
            if (IFID_Valid !== (i > 0) || (i > 0 && IFID_PC !== 32'(4 * (i - 1)))) begin
                errors++; $display("FAIL seq_ifid[%0d]: got pc %h valid %b", i, IFID_PC, IFID_Valid);
            end
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        end
        checks++;
        if ({IFID_PC, IFID_Instr, IFID_Valid} !== {m_ifid_pc, m_ifid_instr, m_ifid_valid}) begin
            errors++; $display("FAIL seq_instr: got %h/%h expected %h/%h", IFID_PC, IFID_Instr, m_ifid_pc, m_ifid_instr);
        end
    endtask

    task automatic test_stall();
        logic [64:0] snap;
        logic [31:0] stall0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        snap = {IFID_PC, IFID_Instr, IFID_Valid};
        stall0 = m_stall;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if (imem_addr !== 32'h10) begin
                errors++; $display("FAIL stall_addr[%0d]: got %h expected 00000010", i, imem_addr);
            end
            checks++;
            if ({IFID_PC, IFID_Instr, IFID_Valid} !== snap) begin
                errors++; $display("FAIL stall_ifid[%0d]: got %h expected %h", i, {IFID_PC, IFID_Instr, IFID_Valid}, snap);
            end
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_stall_cnt !== stall0 + 32'd2) begin
            errors++; $display("FAIL stall_perf: got %0d expected %0d", perf_stall_cnt, stall0 + 32'd2);
        end
`endif
    endtask

    task automatic test_flush_hit();
        go_to(32'h20);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
        checks++;
        if ({imem_addr, IFID_Valid, IFID_Instr} !== {32'h100, 1'b0, NOP}) begin
            errors++; $display("FAIL flush_hit: got addr %h valid %b instr %h expected 00000100/0/%h", imem_addr, IFID_Valid, IFID_Instr, NOP);
        end
    endtask

    task automatic test_flush_miss();
        go_to(32'h40);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_addr !== 32'h40) begin
                errors++; $display("FAIL miss_hold[%0d]: got %h expected 00000040", i, imem_addr);
            end
            if (i < 2) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_addr, IFID_Valid} !== {32'h200, 1'b0}) begin
            errors++; $display("FAIL miss_redirect: got addr %h valid %b expected 00000200/0", imem_addr, IFID_Valid);
        end
    endtask

    task automatic test_double_flush();
        go_to(32'h60);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (imem_addr !== 32'h300) begin
            errors++; $display("FAIL double_flush: got %h expected 00000300", imem_addr);
        end
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_addr, IFID_PC, IFID_Valid} !== {32'h0, 32'hFFFF_FFFC, 1'b1}) begin
            errors++; $display("FAIL wrap: got addr %h ifid_pc %h valid %b expected 00000000/fffffffc/1", imem_addr, IFID_PC, IFID_Valid);
        end
    endtask

    task automatic test_reset_in_discard();
        go_to(32'h80);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (imem_addr !== RESET_PC) begin
            errors++; $display("FAIL rst_discard_addr: got %h expected %h", imem_addr, RESET_PC);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_addr, IFID_PC, IFID_Valid} !== {RESET_PC + 32'd4, RESET_PC, 1'b1}) begin
            errors++; $display("FAIL rst_discard_fetch: got addr %h ifid_pc %h valid %b", imem_addr, IFID_PC, IFID_Valid);
        end
    endtask

    task automatic test_random();
        logic r, pcw, ifw, fl, v;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            pcw = ($urandom_range(0, 3) != 0);
            ifw = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 7) == 0);
            v   = ($urandom_range(0, 2) != 0);
            drive(r, pcw, ifw, fl, $urandom, v);
            checks++;
            if ({imem_addr, IFID_PC, IFID_Instr, IFID_Valid} !== {m_pc, m_ifid_pc, m_ifid_instr, m_ifid_valid}) begin
                errors++;
                $display("FAIL random[%0d]: got %h/%h/%h/%b expected %h/%h/%h/%b", i,
                         imem_addr, IFID_PC, IFID_Instr, IFID_Valid, m_pc, m_ifid_pc, m_ifid_instr, m_ifid_valid);
            end
`ifdef FETCH_PERF_EN
            checks++;
            if ({perf_stall_cnt, perf_flush_cnt} !== {m_stall, m_flush}) begin
                errors++; $display("FAIL random_perf[%0d]: got %0d/%0d expected %0d/%0d", i,
                                   perf_stall_cnt, perf_flush_cnt, m_stall, m_flush);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1; Flush = 1'b0;
        Jump_Target = 32'h0; imem_rdata = 32'h0; imem_valid = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_flush_hit();
        test_flush_miss();
        test_double_flush();
        test_wrap();
        test_reset_in_discard();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
